// File: rtl/div_seq_unit_pkg.sv
// Shared definitions for the iterative RV32M divider.
// - div_func encodings (DIV/DIVU/REM/REMU) and their bit meanings
// - FSM state encoding (IDLE/CALC/DONE)
// - mapping from the ALU divide function codes to div_func
package div_seq_unit_pkg;

  typedef enum logic [1:0] {
    DivFuncDiv  = 2'b00,
    DivFuncDivu = 2'b01,
    DivFuncRem  = 2'b10,
    DivFuncRemu = 2'b11
  } div_func_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  // ALU function codes that the decoder emits for the M-extension divides.
  localparam logic [4:0] AluDiv  = 5'h10;
  localparam logic [4:0] AluDivu = 5'h11;
  localparam logic [4:0] AluRem  = 5'h12;
  localparam logic [4:0] AluRemu = 5'h13;

  // Bit 1 selects remainder, bit 0 selects unsigned.
  function automatic logic func_is_rem(input logic [1:0] f);
    return f[1];
  endfunction

  function automatic logic func_is_signed(input logic [1:0] f);
    return ~f[0];
  endfunction

  function automatic div_func_e alu_to_div_func(input logic [4:0] alu_func);
    div_func_e f;
    unique case (alu_func)
      AluDiv:  f = DivFuncDiv;
      AluDivu: f = DivFuncDivu;
      AluRem:  f = DivFuncRem;
      AluRemu: f = DivFuncRemu;
      default: f = DivFuncDivu;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/div_seq_unit_if.sv
// EX-stage <-> divider handshake bundle.
// master (EX stage): drives div_req/div_func/div_opa/div_opb/div_flush,
//                    receives div_stall/div_done/div_res.
// slave  (divider) : the reverse.
interface div_seq_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            div_req;
  logic [1:0]      div_func;
  logic [XLEN-1:0] div_opa;
  logic [XLEN-1:0] div_opb;
  logic            div_flush;
  logic            div_stall;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  modport master (
    output div_req, div_func, div_opa, div_opb, div_flush,
    input  div_stall, div_done, div_res
  );

  modport slave (
    input  div_req, div_func, div_opa, div_opb, div_flush,
    output div_stall, div_done, div_res
  );

endinterface

// File: rtl/div_seq_unit_step.sv
// One restoring-division iteration, purely combinational.
// rem      : current remainder accumulator (XLEN+1 bits)
// dvd_msb  : dividend bit being brought down this step
// divisor  : unsigned divisor magnitude
// rem_next : accumulator after the conditional subtract
// q_bit    : quotient bit produced by this step
module div_seq_unit_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic            q_bit
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    rem_sh   = {rem[XLEN-1:0], dvd_msb};
    diff     = rem_sh - {1'b0, divisor};
    // A set top bit can only mean the accumulator already exceeds any divisor.
    q_bit    = rem[XLEN] | (rem_sh >= {1'b0, divisor});
    rem_next = q_bit ? diff : rem_sh;
  end

endmodule

// File: rtl/div_seq_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU unit beside the EX stage.
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of div_seq_unit_if (req/func/operands/flush in,
//            stall/done/result out)
// One quotient bit per cycle; divide-by-zero and signed overflow take a
// one-cycle fast path. div_res is only meaningful while div_done is high.
module div_seq_unit
  import div_seq_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  div_seq_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] dvd_q, dvs_q, quo_q, res_q;
  logic [XLEN:0]   rem_q;
  logic            is_rem_q, q_neg_q, r_neg_q;

  logic            op_signed, opa_neg, opb_neg;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic            div_zero, ovf, special, accept, last_step;

  logic [XLEN:0]   rem_nxt;
  logic            q_bit;
  logic [XLEN-1:0] quo_nxt, fin_q, fin_r, fin_res;

  // Operand conditioning and the fast-path decode for an IDLE accept.
  always_comb begin
    op_signed = func_is_signed(bus.div_func);
    opa_neg   = op_signed & bus.div_opa[XLEN-1];
    opb_neg   = op_signed & bus.div_opb[XLEN-1];
    abs_a     = opa_neg ? -bus.div_opa : bus.div_opa;
    abs_b     = opb_neg ? -bus.div_opb : bus.div_opb;
    div_zero  = (bus.div_opb == '0);
    ovf       = op_signed && (bus.div_opa == {1'b1, {(XLEN-1){1'b0}}}) && (bus.div_opb == '1);
    special   = div_zero | ovf;
    if (div_zero) begin
      special_res = func_is_rem(bus.div_func) ? bus.div_opa : '1;
    end else begin
      // Overflow: quotient is the dividend (most negative), remainder zero.
      special_res = func_is_rem(bus.div_func) ? '0 : bus.div_opa;
    end
    accept    = (state_q == StIdle) && bus.div_req && !bus.div_flush;
    last_step = (cnt_q == CNT_W'(XLEN-1));
  end

  div_seq_unit_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[XLEN-1]),
    .divisor  (dvs_q),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_comb begin
    quo_nxt = {quo_q[XLEN-2:0], q_bit};
    fin_q   = q_neg_q ? -quo_nxt : quo_nxt;
    fin_r   = r_neg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
    fin_res = is_rem_q ? fin_r : fin_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.div_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (bus.div_req) state_d = special ? StDone : StCalc;
        StCalc: if (last_step) state_d = StDone;
        // The req seen next cycle belongs to the following instruction.
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.div_stall = bus.div_req && (state_q != StDone) && !bus.div_flush && !rst;
    bus.div_done  = (state_q == StDone);
    bus.div_res   = res_q;
  end

  // Datapath: latch on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (!bus.div_flush) begin
      if (accept) begin
        dvd_q    <= abs_a;
        dvs_q    <= abs_b;
        rem_q    <= '0;
        quo_q    <= '0;
        cnt_q    <= '0;
        is_rem_q <= func_is_rem(bus.div_func);
        q_neg_q  <= opa_neg ^ opb_neg;
        r_neg_q  <= opa_neg;
        if (special) res_q <= special_res;
      end else if (state_q == StCalc) begin
        rem_q <= rem_nxt;
        dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
        quo_q <= quo_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) res_q <= fin_res;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed bench for div_seq_unit. A transaction-level model predicts, for
// every cycle, div_stall, div_done and div_res; hand-computed results pin the
// model on each completed operation.
module tb_div_seq_unit;
  import div_seq_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  div_seq_unit_if #(.XLEN(32)) bus ();

  div_seq_unit #(
    .XLEN(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int          cyc       = 0;
  bit          armed     = 1'b0;
  bit          pend      = 1'b0;
  int          done_cyc  = 0;
  logic [31:0] cur_res   = '0;
  logic [31:0] last_res  = '0;
  logic [31:0] lit_res   = '0;
  int          n_chk     = 0;
  int          n_pass    = 0;

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, b);
    return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension result rules in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, b);
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
    case (f)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, b);
    return is_special(f, a, b) ? 1 : 33;
  endfunction

  // Model: advances once per clock using the inputs of the cycle just ended.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      pend     = 1'b0;
      last_res = '0;
      armed    = 1'b1;
    end else if (pend && cyc == done_cyc) begin
      pend     = 1'b0;
      last_res = cur_res;
    end else if (bus.div_flush) begin
      pend = 1'b0;
    end else if (!pend && bus.div_req) begin
      pend     = 1'b1;
      cur_res  = ref_res(bus.div_func, bus.div_opa, bus.div_opb);
      done_cyc = cyc + ref_lat(bus.div_func, bus.div_opa, bus.div_opb);
    end
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
  endtask

  // Compare on the falling edge, away from the active edge.
  initial forever begin
    logic        e_done, e_stall;
    logic [31:0] e_res;
    @(negedge clk);
    if (armed) begin
      e_done  = pend && (cyc == done_cyc);
      e_stall = bus.div_req && !bus.div_flush && !rst && !e_done;
      e_res   = e_done ? cur_res : last_res;
      check("stall", {31'b0, bus.div_stall}, {31'b0, e_stall});
      check("done",  {31'b0, bus.div_done},  {31'b0, e_done});
      check("res",   bus.div_res, e_res);
      if (e_done) check("res_literal", bus.div_res, lit_res);
    end
  end

  task automatic op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] e, input int n);
    bus.div_req  = 1'b1;
    bus.div_func = f;
    bus.div_opa  = a;
    bus.div_opb  = b;
    lit_res      = e;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.div_req   = 1'b0;
    bus.div_flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.div_req   = 1'b0;
    bus.div_func  = 2'b00;
    bus.div_opa   = '0;
    bus.div_opb   = '0;
    bus.div_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Normal path: req held for cycles 0..33, done at 33.
    op(DivFuncDivu, 32'd100, 32'd7, 32'd14, 34);                 idle(1);
    op(DivFuncRemu, 32'd100, 32'd7, 32'd2, 34);                  idle(1);
    op(DivFuncDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);     idle(1);
    op(DivFuncRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);     idle(1);
    op(DivFuncRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);             idle(1);

    // Fast path: done at cycle 1.
    op(DivFuncDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);             idle(1);
    op(DivFuncRem, 32'h1234_5678, 32'd0, 32'h1234_5678, 2);      idle(1);
    op(DivFuncDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2); idle(1);
    op(DivFuncRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);      idle(1);

    // Flush in cycle 10, quiet cycle 11, new op at 12 completing at 45.
    op(DivFuncDivu, 32'd1000, 32'd3, 32'd333, 10);
    bus.div_flush = 1'b1;
    @(posedge clk);
    #1;
    idle(1);
    op(DivFuncDivu, 32'd9, 32'd3, 32'd3, 34);                    idle(1);

    // Back-to-back with req held: done at 33 and 67.
    op(DivFuncDivu, 32'd100, 32'd10, 32'd10, 34);
    op(DivFuncDiv, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6, 34);
    idle(1);

    // Reset in the middle of CALC clears result and done.
    op(DivFuncDivu, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 6);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
